// File: rtl/mux_n_to_1_stream.sv
// mux_n_to_1_stream: registered N-to-1 valid/ready word mux; define MUX_RR_EN to add the rr_mode round-robin arbiter.
module mux_n_to_1_stream #(
   parameter int WIDTH = 32,
   parameter int N = 3,
   parameter int SEL_W = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [N*WIDTH-1:0] in_data,
   input  logic [N-1:0]     in_valid,
   output logic [N-1:0]     in_ready,
   input  logic [SEL_W-1:0] sel,
`ifdef MUX_RR_EN
   input  logic             rr_mode,
`endif
   output logic [WIDTH-1:0] out_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [SEL_W-1:0] out_chan,
   output logic             err
);
   localparam int P = 1 << SEL_W;
   logic [WIDTH-1:0] words [P];
   logic [P-1:0] valid_pad;
   logic sel_ok, sel_v, sel_mode, gnt_v, load_en, xfer;
   logic [SEL_W-1:0] gnt;
   for (genvar i = 0; i < P; i++) begin : g_words
      if (i < N) begin : g_ch
         assign words[i] = in_data[i*WIDTH +: WIDTH];
      end else begin : g_pad
         assign words[i] = '0;
      end
   end
   assign valid_pad = P'(in_valid);
   assign sel_ok = int'(sel) < N;
   assign sel_v = sel_ok && valid_pad[sel];
   assign load_en = !out_valid || out_ready;
`ifdef MUX_RR_EN
   logic [SEL_W-1:0] ptr, rr_g;
   logic rr_v;
   int best, dist;
   // Closest valid channel at or after ptr, measured as distance modulo N.
   always_comb begin
      rr_g = '0;
      best = N;
      dist = 0;
      for (int i = 0; i < N; i++) begin
         dist = (i + N - int'(ptr)) % N;
         if (in_valid[i] && dist < best) begin
            best = dist;
            rr_g = SEL_W'(i);
         end
      end
      rr_v = best < N;
   end
   assign sel_mode = !rr_mode;
   assign gnt_v = rr_mode ? rr_v : sel_v;
   assign gnt = rr_mode ? rr_g : sel;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) ptr <= '0;
      else if (xfer && rr_mode) ptr <= (int'(gnt) == N - 1) ? '0 : gnt + 1'b1;
`else
   assign sel_mode = 1'b1;
   assign gnt_v = sel_v;
   assign gnt = sel;
`endif
   assign xfer = load_en && gnt_v;
   assign in_ready = (xfer && rst_n) ? N'(1) << gnt : '0;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         out_data <= '0;
         out_valid <= 1'b0;
         out_chan <= '0;
         err <= 1'b0;
      end else begin
         err <= sel_mode && !sel_ok;
         if (xfer) begin
            out_data <= words[gnt];
            out_chan <= gnt;
            out_valid <= 1'b1;
         end else if (out_ready) begin
            out_data <= '0;
            out_valid <= 1'b0;
            out_chan <= '0;
         end
      end
endmodule

// File: tb/tb_mux_n_to_1_stream.sv
// tb_mux_n_to_1_stream: directed and randomized checks of mux_n_to_1_stream against a cycle-level model.
module tb_mux_n_to_1_stream;
   localparam int WIDTH = 32;
   localparam int N = 3;
   localparam int SEL_W = 2;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic [WIDTH-1:0] w [N];
   logic [N*WIDTH-1:0] in_data;
   logic [N-1:0] in_valid = '0;
   logic [N-1:0] in_ready;
   logic [SEL_W-1:0] sel = '0;
   logic rr_mode = 1'b0;
   logic [WIDTH-1:0] out_data;
   logic out_valid;
   logic out_ready = 1'b0;
   logic [SEL_W-1:0] out_chan;
   logic err;
   logic m_valid, m_err;
   logic [WIDTH-1:0] m_data;
   int m_chan, m_ptr;
   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;
   assign in_data = {w[2], w[1], w[0]};

   mux_n_to_1_stream #(.WIDTH(WIDTH), .N(N), .SEL_W(SEL_W)) dut (
      .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .sel(sel),
`ifdef MUX_RR_EN
      .rr_mode(rr_mode),
`endif
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan), .err(err)
   );

   task automatic model_reset();
      m_valid = 1'b0;
      m_err = 1'b0;
      m_data = '0;
      m_chan = 0;
      m_ptr = 0;
   endtask

   function automatic void grant(output logic v, output int g);
      int c;
      v = 1'b0;
      g = 0;
      if (rr_mode) begin
         for (int k = 0; k < N; k++) begin
            c = (m_ptr + k) % N;
            if (!v && in_valid[c]) begin
               v = 1'b1;
               g = c;
            end
         end
      end else if (int'(sel) < N && in_valid[sel]) begin
         v = 1'b1;
         g = int'(sel);
      end
   endfunction

   task automatic tick();
      logic gv, ld;
      int g;
      grant(gv, g);
      ld = !m_valid || out_ready;
      @(posedge clk);
      m_err = !rr_mode && int'(sel) >= N;
      if (ld && gv) begin
         m_data = w[g];
         m_chan = g;
         m_valid = 1'b1;
         if (rr_mode) m_ptr = (g + 1) % N;
      end else if (m_valid && out_ready) begin
         m_valid = 1'b0;
         m_data = '0;
         m_chan = 0;
      end
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      in_valid = 3'b111;
      out_ready = 1'b1;
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %0h want 0", out_valid); end
      n_vec++; if (out_data !== 32'h0) begin n_err++; $display("FAIL rst_data: got %0h want 0", out_data); end
      n_vec++; if (out_chan !== 2'd0) begin n_err++; $display("FAIL rst_chan: got %0h want 0", out_chan); end
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL rst_err: got %0h want 0", err); end
      n_vec++; if (in_ready !== 3'b000) begin n_err++; $display("FAIL rst_ready: got %0b want 000", in_ready); end
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      sel = 2'd1;
      in_valid = 3'b010;
      w[1] = 32'h12345678;
      out_ready = 1'b0;
      tick();
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL mid_load: got %0h want 1", out_valid); end
      #2;
      rst_n = 1'b0;
      #1;
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %0h want 0", out_valid); end
      n_vec++; if (out_data !== 32'h0) begin n_err++; $display("FAIL mid_rst_data: got %0h want 0", out_data); end
      n_vec++; if (out_chan !== 2'd0) begin n_err++; $display("FAIL mid_rst_chan: got %0h want 0", out_chan); end
      n_vec++; if (in_ready !== 3'b000) begin n_err++; $display("FAIL mid_rst_ready: got %0b want 000", in_ready); end
      model_reset();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      in_valid = '0;
   endtask

   task automatic test_select();
      sel = 2'd1;
      in_valid = 3'b010;
      w[1] = 32'hCCCCCCCC;
      out_ready = 1'b1;
      #1;
      n_vec++; if (in_ready !== 3'b010) begin n_err++; $display("FAIL sel_ready: got %0b want 010", in_ready); end
      tick();
      n_vec++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL sel_valid: got %0h want 1", out_valid); end
      n_vec++; if (out_data !== 32'hCCCCCCCC) begin n_err++; $display("FAIL sel_data: got %0h want cccccccc", out_data); end
      n_vec++; if (out_chan !== 2'd1) begin n_err++; $display("FAIL sel_chan: got %0h want 1", out_chan); end
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL sel_err: got %0h want 0", err); end
      in_valid = '0;
      tick();
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL idle_valid: got %0h want 0", out_valid); end
      n_vec++; if (out_data !== 32'h0) begin n_err++; $display("FAIL idle_data: got %0h want 0", out_data); end
   endtask

   task automatic test_backpressure();
      sel = 2'd1;
      in_valid = 3'b010;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      sel = 2'd2;
      in_valid = 3'b100;
      w[2] = 32'hDDDDDDDD;
      #1;
      n_vec++; if (in_ready !== 3'b000) begin n_err++; $display("FAIL bp_ready: got %0b want 000", in_ready); end
      tick();
      n_vec++; if (out_data !== 32'hCCCCCCCC) begin n_err++; $display("FAIL bp_hold: got %0h want cccccccc", out_data); end
      n_vec++; if (out_chan !== 2'd1) begin n_err++; $display("FAIL bp_chan: got %0h want 1", out_chan); end
      out_ready = 1'b1;
      #1;
      n_vec++; if (in_ready !== 3'b100) begin n_err++; $display("FAIL bp_release: got %0b want 100", in_ready); end
      tick();
      n_vec++; if (out_data !== 32'hDDDDDDDD) begin n_err++; $display("FAIL bp_data: got %0h want dddddddd", out_data); end
      n_vec++; if (out_chan !== 2'd2) begin n_err++; $display("FAIL bp_chan2: got %0h want 2", out_chan); end
   endtask

   task automatic test_oob();
      sel = 2'd3;
      in_valid = 3'b111;
      out_ready = 1'b1;
      #1;
      n_vec++; if (in_ready !== 3'b000) begin n_err++; $display("FAIL oob_ready: got %0b want 000", in_ready); end
      tick();
      n_vec++; if (err !== 1'b1) begin n_err++; $display("FAIL oob_err: got %0h want 1", err); end
      n_vec++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL oob_drain: got %0h want 0", out_valid); end
      sel = 2'd0;
      in_valid = '0;
      tick();
      n_vec++; if (err !== 1'b0) begin n_err++; $display("FAIL oob_err_clear: got %0h want 0", err); end
   endtask

   task automatic test_rr();
`ifdef MUX_RR_EN
      int seq [7] = '{0, 1, 2, 0, 2, 0, 2};
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      model_reset();
      rr_mode = 1'b1;
      in_valid = 3'b111;
      out_ready = 1'b1;
      for (int k = 0; k < 7; k++) begin
         if (k == 4) in_valid = 3'b101;
         tick();
         n_vec++; if (out_valid !== 1'b1 || out_chan !== SEL_W'(seq[k])) begin n_err++; $display("FAIL rr_seq%0d: got v=%0h ch=%0d want v=1 ch=%0d", k, out_valid, out_chan, seq[k]); end
      end
      rr_mode = 1'b0;
      in_valid = '0;
`endif
   endtask

   task automatic test_back_to_back();
      logic [WIDTH-1:0] q [$];
      logic [WIDTH-1:0] exp_w;
      rr_mode = 1'b0;
      in_valid = '0;
      out_ready = 1'b1;
      tick();
      sel = 2'd0;
      in_valid = 3'b001;
      for (int k = 0; k < 8; k++) begin
         w[0] = $urandom;
         q.push_back(w[0]);
         #1;
         n_vec++; if (in_ready !== 3'b001) begin n_err++; $display("FAIL b2b_ready%0d: got %0b want 001", k, in_ready); end
         tick();
         exp_w = q.pop_front();
         n_vec++; if (out_valid !== 1'b1 || out_data !== exp_w) begin n_err++; $display("FAIL b2b_word%0d: got v=%0h d=%0h want v=1 d=%0h", k, out_valid, out_data, exp_w); end
      end
      in_valid = '0;
   endtask

   task automatic test_random();
      logic gv;
      int g;
      logic [N-1:0] exp_rdy;
      for (int c = 0; c < 400; c++) begin
         in_valid = N'($urandom);
         sel = SEL_W'($urandom);
         out_ready = ($urandom % 4) != 0;
         for (int i = 0; i < N; i++) w[i] = $urandom;
`ifdef MUX_RR_EN
         rr_mode = ($urandom % 2) != 0;
`endif
         #1;
         grant(gv, g);
         exp_rdy = ((!m_valid || out_ready) && gv) ? N'(1) << g : '0;
         n_vec++; if (in_ready !== exp_rdy) begin n_err++; $display("FAIL rnd_ready%0d: got %0b want %0b", c, in_ready, exp_rdy); end
         n_vec++; if (out_valid !== m_valid) begin n_err++; $display("FAIL rnd_valid%0d: got %0h want %0h", c, out_valid, m_valid); end
         n_vec++; if (out_data !== m_data) begin n_err++; $display("FAIL rnd_data%0d: got %0h want %0h", c, out_data, m_data); end
         n_vec++; if (out_chan !== SEL_W'(m_chan)) begin n_err++; $display("FAIL rnd_chan%0d: got %0d want %0d", c, out_chan, m_chan); end
         n_vec++; if (err !== m_err) begin n_err++; $display("FAIL rnd_err%0d: got %0h want %0h", c, err, m_err); end
         tick();
      end
   endtask

   initial begin
      for (int i = 0; i < N; i++) w[i] = '0;
      model_reset();
      test_reset();
      test_select();
      test_backpressure();
      test_oob();
      test_rr();
      test_back_to_back();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
